// File: rtl/branch_pc_sequencer.sv
// Fetch-side bundle PC controller: sequential advance, branch redirects, wrong-path squash pulse.
// All outputs are registered; redirects seen during stall are held and applied on release.
module branch_pc_sequencer #(
   parameter int unsigned BUNDLE_BYTES  = 16,
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int unsigned SQUASH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        halt,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] new_pc,
   output logic [31:0] fetch_pc,
   output logic        fetch_valid,
   output logic        branch_squash,
   output logic        redirect_pending,
   output logic        misaligned_err,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      SQUASH = 2'd2,
      HALTED = 2'd3
   } state_e;

   localparam logic [2:0]  SQ_INIT = 3'(SQUASH_CYCLES);
   localparam logic [31:0] PC_INC  = 32'(BUNDLE_BYTES);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        pend_q, pend_d;
   logic        squash_q, squash_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] tgt;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      pend_d    = pend_q;
      squash_d  = squash_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      tgt       = branch_taken ? new_pc : pend_pc_q;

      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         HALTED: begin
            if (start && !halt) state_d = RUN;
         end
         default: begin
            if (halt) begin
               // Halt beats everything; an aligned live target is still latched as the resume PC.
               state_d  = HALTED;
               squash_d = 1'b0;
               cnt_d    = 3'd0;
               pend_d   = 1'b0;
               if (branch_taken) begin
                  if (new_pc[1:0] == 2'b00) pc_d = new_pc;
                  else                      err_d = 1'b1;
               end
            end else if (stall) begin
               if (branch_taken) begin
                  pend_d    = 1'b1;
                  pend_pc_d = new_pc;
               end
            end else begin
               pend_d = 1'b0;
               if (branch_taken || pend_q) begin
                  if (tgt[1:0] == 2'b00) begin
                     pc_d     = tgt;
                     state_d  = SQUASH;
                     cnt_d    = SQ_INIT;
                     squash_d = 1'b1;
                  end else begin
                     err_d    = 1'b1;
                     state_d  = HALTED;
                     squash_d = 1'b0;
                     cnt_d    = 3'd0;
                  end
               end else begin
                  pc_d = pc_q + PC_INC;
                  if (state_q == SQUASH) begin
                     cnt_d = cnt_q - 3'd1;
                     if (cnt_q == 3'd1) begin
                        squash_d = 1'b0;
                        state_d  = RUN;
                     end
                  end
               end
            end
         end
      endcase

      valid_d = (state_d == RUN) || (state_d == SQUASH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         pend_pc_q <= 32'h0;
         pend_q    <= 1'b0;
         squash_q  <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= 3'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         pend_q    <= pend_d;
         squash_q  <= squash_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign fetch_pc         = pc_q;
   assign fetch_valid      = valid_q;
   assign branch_squash    = squash_q;
   assign redirect_pending = pend_q;
   assign misaligned_err   = err_q;
   assign state            = state_q;

endmodule

// File: doc/branch_pc_sequencer.md
Name: branch_pc_sequencer

Overview:
- Fetch-side PC controller for the VLIW core.
- Owns the bundle PC and advances it by one bundle per unstalled cycle.
- Applies redirects from the branch pipeline's branch_taken/new_pc.
- Generates the registered branch_squash pulse that the branch lane, and the other lanes' ID/EX registers, OR into decode nop so the wrong-path bundle is killed.

Parameters:
- BUNDLE_BYTES, 16, byte increment per bundle (4 lanes x 4 bytes).
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- SQUASH_CYCLES, 1, number of unstalled cycles branch_squash stays asserted after a redirect; legal range 1-7.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-low.
- start  in  1  leave IDLE/HALTED and begin fetching.
- halt  in  1  stop fetching at the next edge.
- stall  in  1  global pipeline stall.
- branch_taken  in  1  redirect request from the branch execute stage.
- new_pc  in  32  redirect target, valid when branch_taken=1.
- fetch_pc  out  32  current bundle PC; also drives inst_pc for the decode stage.
- fetch_valid  out  1  fetch_pc is a live fetch address.
- branch_squash  out  1  kill the bundle currently in decode.
- redirect_pending  out  1  a redirect has been captured during stall and not yet applied.
- misaligned_err  out  1  sticky; set when a target has new_pc[1:0] != 0.
- state  out  2  IDLE=0, RUN=1, SQUASH=2, HALTED=3.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - fetch_pc=RESET_PC
  - state=IDLE
  - fetch_valid=0
  - branch_squash=0
  - redirect_pending=0
  - misaligned_err=0
  - squash counter=0
  - pending target register=0
- Reset mid-operation discards any pending redirect and any squash in progress.
- All outputs are registered. fetch_valid = (state==RUN || state==SQUASH).
- IDLE: fetch_pc holds. start=1 -> RUN.
- RUN, stall=0, no redirect: fetch_pc <= fetch_pc + BUNDLE_BYTES, modulo 2^32 (32'hFFFF_FFF0 + 16 wraps to 0).
- stall=1: fetch_pc, the squash counter and branch_squash all hold.
- Redirect applied (branch_taken=1, stall=0, state RUN or SQUASH, new_pc[1:0]==0):
  - fetch_pc <= new_pc.
  - state <= SQUASH.
  - Counter <= SQUASH_CYCLES.
  - branch_squash=1 from the next cycle.
  - Latency is 1 cycle: the target appears on fetch_pc in the cycle after branch_taken.
- SQUASH:
  - Each unstalled cycle: fetch_pc advances by BUNDLE_BYTES and the counter decrements.
  - When the counter reaches 0: branch_squash drops in the same edge and state -> RUN.
  - A new redirect in SQUASH restarts the sequence; the newest target wins.
- Redirect during stall (branch_taken=1, stall=1):
  - Capture new_pc into the pending register and set redirect_pending=1.
  - On the first cycle with stall=0, apply it as a normal redirect, then clear redirect_pending.
  - A second branch_taken while still stalled overwrites the pending target.
  - A live branch_taken on the release cycle beats the pending target.
- Misaligned target (new_pc[1:0] != 0): no redirect; misaligned_err <= 1; state <= HALTED; branch_squash <= 0.
  - Applies equally to a pending target at stall release.
- halt=1 in RUN/SQUASH:
  - state <= HALTED; fetch_valid <= 0; branch_squash <= 0; counter <= 0.
  - If branch_taken is also asserted with an aligned target, fetch_pc still takes new_pc, but HALTED wins and no squash is issued.
- HALTED: fetch_pc holds.
  - start=1 -> RUN from the held fetch_pc.
  - misaligned_err clears only on reset.
  - start and halt together: halt wins.
- branch_taken in IDLE or HALTED is ignored.

Test Plan:
- Reset, then start with stall=0 for 4 cycles -> fetch_pc 0x00, 0x10, 0x20, 0x30; fetch_valid=1 from the cycle after start.
- At fetch_pc=0x40, pulse branch_taken with new_pc=0x1000 -> next cycle fetch_pc=0x1000, branch_squash=1 for exactly 1 cycle, state=2 then 1; next fetch_pc=0x1010.
- stall=1 for 3 cycles with branch_taken=1 and new_pc=0x2000 in the 2nd cycle -> fetch_pc frozen, redirect_pending=1; on the first cycle after release fetch_pc=0x2000, branch_squash=1, redirect_pending=0.
- branch_taken with new_pc=0x3002 -> misaligned_err=1, state=3, fetch_valid=0, fetch_pc unchanged, no squash; start -> state=1, misaligned_err stays 1.
- fetch_pc=0xFFFF_FFF0 with no redirect -> next fetch_pc=0x0000_0000; with SQUASH_CYCLES=3 plus one stall cycle mid-squash -> branch_squash high for 4 cycles.
- Assert rst=0 mid-SQUASH with redirect_pending=1 -> immediately fetch_pc=RESET_PC, all flags 0, state=0.
